// File: rtl/oled_msg_sequencer.sv
// Feeds a fixed five-byte ASCII message into the OLED controller's byte port,
// one strobe at a time, with gap spacing, back-pressure and a stall timeout.
module oled_msg_sequencer #(
  parameter int GAP_CYCLES  = 4,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       msg_sel,
  input  logic       buffer_full,
  output logic [7:0] data_out,
  output logic       write_enable,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] byte_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WRITE,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  logic [7:0] data_q, data_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  function automatic logic [7:0] rom_byte(input logic sel, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case ({sel, idx})
      4'b0_000: b = 8'h68;
      4'b0_001: b = 8'h65;
      4'b0_010: b = 8'h6C;
      4'b0_011: b = 8'h6C;
      4'b0_100: b = 8'h6F;
      4'b1_000: b = 8'h77;
      4'b1_001: b = 8'h6F;
      4'b1_010: b = 8'h72;
      4'b1_011: b = 8'h6C;
      4'b1_100: b = 8'h64;
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      idx_q   <= 3'd0;
      stall_q <= '0;
      gap_q   <= '0;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start && !abort) begin
          state_d = S_WAIT_RDY;
          sel_d   = msg_sel;
          idx_d   = 3'd0;
          stall_d = '0;
        end
      end
      S_WAIT_RDY: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end else if (!buffer_full) begin
          state_d = S_WRITE;
        end else begin
          // Saturating, so a long stall can never wrap back below the limit.
          if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
          if (int'(stall_q) + 1 >= STALL_LIMIT) state_d = S_ERR;
        end
      end
      S_WRITE: begin
        stall_d = '0;
        gap_d   = CNT_W'(GAP_CYCLES);
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end else if (idx_q == 3'd4) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_WAIT_RDY;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end else begin
          gap_d = gap_q - 1'b1;
          if (gap_q <= CNT_W'(1)) state_d = S_WAIT_RDY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail it by one cycle.
  always_comb begin
    data_d = data_q;
    if (state_q == S_WRITE) data_d = rom_byte(sel_q, idx_q);
    we_d   = (state_q == S_WRITE);
    busy_d = (state_q != S_IDLE) && (state_q != S_ERR);
    done_d = (state_q == S_DONE) && !abort;
    err_d  = (state_q == S_ERR);
  end

  assign data_out     = data_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign byte_idx     = idx_q;

endmodule
